ai_predictor: RTL and testbench

// Parametrised computer-player paddle controller for the pong game. Captures ball motion as
// it crosses the net, predicts the wall-reflected intercept at the AI paddle column, then

---
 rtl/ai_predictor_if.sv | 31 +++
 rtl/ai_predictor.sv | 163 ++++++++++++++++
 tb/tb_ai_predictor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ai_predictor_if.sv
// ai_predictor_if: ball-position input bus and paddle-controller outputs for ai_predictor.
//   BALL_STEP  1-cycle strobe, BALL_H/BALL_V valid this cycle
//   BALL_H     ball column (HW bits)
//   BALL_V     ball row (HW bits)
//   POSITION   scaled paddle top row (POS_W bits)
//   TARGET     current paddle target row (HW bits)
//   PRED_VALID 1-cycle pulse when TARGET is loaded by a prediction
//   BUSY       prediction in progress
// master: game logic side (drives ball); slave: the predictor.
interface ai_predictor_if #(
  parameter int unsigned HW    = 11,
  parameter int unsigned POS_W = 8
);
  logic             BALL_STEP;
  logic [HW-1:0]    BALL_H;
  logic [HW-1:0]    BALL_V;
  logic [POS_W-1:0] POSITION;
  logic [HW-1:0]    TARGET;
  logic             PRED_VALID;
  logic             BUSY;

  modport master (
    output BALL_STEP, BALL_H, BALL_V,
    input  POSITION, TARGET, PRED_VALID, BUSY
  );

  modport slave (
    input  BALL_STEP, BALL_H, BALL_V,
    output POSITION, TARGET, PRED_VALID, BUSY
  );
endinterface

// File: rtl/ai_predictor.sv
// ai_predictor: computer-player paddle controller for pong.
// Captures the ball row at the net column, takes its direction one column later, projects
// the row to the paddle column folding off the top/bottom walls, then slews the paddle
// toward the resulting target one pixel every SPEED_DIV clocks.
// Ports:
//   CLOCK  system clock
//   RESET  asynchronous, active-high reset
//   bus    ai_predictor_if.slave (BALL_STEP/BALL_H/BALL_V in; POSITION/TARGET/PRED_VALID/BUSY out)
// Optional feature: define PONG_AI_JITTER_EN to add an LFSR-driven -8..+7 offset to targets.
module ai_predictor #(
  parameter int unsigned HW         = 11,
  parameter int unsigned V_MAX      = 474,
  parameter int unsigned NET_H      = 390,
  parameter int unsigned PADDLE_H   = 770,
  parameter int unsigned PADDLE_LEN = 32,
  parameter int unsigned SPEED_DIV  = 500000,
  parameter int unsigned POS_SHIFT  = 1,
  parameter int unsigned POS_W      = 8
) (
  input logic           CLOCK,
  input logic           RESET,
  ai_predictor_if.slave bus
);

  localparam int unsigned RW      = HW + 2;
  localparam int unsigned PAD_MAX = V_MAX - PADDLE_LEN;
  localparam int unsigned HOME    = PAD_MAX / 2;
  localparam int unsigned CW      = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;

  localparam logic signed [RW-1:0] D_S        = RW'(PADDLE_H - NET_H);
  localparam logic signed [RW-1:0] VMAX_S     = RW'(V_MAX);
  localparam logic signed [RW-1:0] TWO_VMAX_S = RW'(2 * V_MAX);
  localparam logic signed [RW-1:0] HALF_S     = RW'(PADDLE_LEN / 2);
  localparam logic signed [RW-1:0] PADMAX_S   = RW'(PAD_MAX);
  localparam logic [HW-1:0]        HOME_U     = HW'(HOME);
  localparam logic [HW-1:0]        PADMAX_U   = HW'(PAD_MAX);
  localparam logic [HW-1:0]        NET_U      = HW'(NET_H);
  localparam logic [HW-1:0]        NET_P1_U   = HW'(NET_H + 1);
  localparam logic [CW-1:0]        CNT_LAST   = CW'(SPEED_DIV - 1);

  typedef enum logic [1:0] {StIdle, StMeasure, StFold, StClamp} state_e;

  state_e                r_state, w_state_nxt;
  logic [HW-1:0]         r_v0, w_v0_nxt;
  logic signed [RW-1:0]  r_raw, w_raw_nxt;
  logic [HW-1:0]         r_target, w_target_nxt;
  logic                  r_pred_valid, w_pred_valid_nxt;
  logic [CW-1:0]         r_cnt;
  logic                  w_tick;
  logic [HW-1:0]         r_paddle, w_paddle_nxt;
  logic [POS_W-1:0]      r_position;
  logic signed [RW-1:0]  w_jit;
  logic signed [RW-1:0]  w_t;
  logic [HW-1:0]         w_t_sat;

`ifdef PONG_AI_JITTER_EN
  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, shifts toward the MSB.
  logic [7:0] r_lfsr;
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) r_lfsr <= 8'hA5;
    else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_jit = $signed({{(RW-4){1'b0}}, r_lfsr[3:0]}) - $signed(RW'(8));
`else
  assign w_jit = '0;
`endif

  // Target is the paddle top edge, so centre the paddle on the predicted row.
  always_comb begin
    w_t = r_raw - HALF_S + w_jit;
    if (w_t[RW-1])          w_t_sat = '0;
    else if (w_t > PADMAX_S) w_t_sat = PADMAX_U;
    else                    w_t_sat = w_t[HW-1:0];
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_v0_nxt         = r_v0;
    w_raw_nxt        = r_raw;
    w_target_nxt     = r_target;
    w_pred_valid_nxt = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.BALL_STEP && bus.BALL_H == NET_U) begin
          w_v0_nxt    = bus.BALL_V;
          w_state_nxt = StMeasure;
        end
      end
      StMeasure: begin
        if (bus.BALL_STEP) begin
          if (bus.BALL_H == NET_P1_U) begin
            // Larger row means moving down the screen; equal rows count as up.
            if (bus.BALL_V > r_v0) w_raw_nxt = $signed({2'b00, r_v0}) + D_S;
            else                   w_raw_nxt = $signed({2'b00, r_v0}) - D_S;
            w_state_nxt = StFold;
          end else if (bus.BALL_H == NET_U) begin
            w_v0_nxt = bus.BALL_V;
          end else begin
            // Ball is heading away from us: park at home.
            w_target_nxt = HOME_U;
            w_state_nxt  = StIdle;
          end
        end
      end
      StFold: begin
        // One wall reflection per cycle until the row lands inside the field.
        if (r_raw > VMAX_S)  w_raw_nxt = TWO_VMAX_S - r_raw;
        else if (r_raw[RW-1]) w_raw_nxt = -r_raw;
        else                 w_state_nxt = StClamp;
      end
      StClamp: begin
        w_target_nxt     = w_t_sat;
        w_pred_valid_nxt = 1'b1;
        w_state_nxt      = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state      <= StIdle;
      r_v0         <= '0;
      r_raw        <= '0;
      r_target     <= HOME_U;
      r_pred_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_v0         <= w_v0_nxt;
      r_raw        <= w_raw_nxt;
      r_target     <= w_target_nxt;
      r_pred_valid <= w_pred_valid_nxt;
    end
  end

  assign w_tick = (r_cnt == CNT_LAST);

  always_comb begin
    w_paddle_nxt = r_paddle;
    if (w_tick) begin
      if (r_paddle < r_target)      w_paddle_nxt = r_paddle + 1'b1;
      else if (r_paddle > r_target) w_paddle_nxt = r_paddle - 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_cnt      <= '0;
      r_paddle   <= HOME_U;
      r_position <= POS_W'(HOME_U >> POS_SHIFT);
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
      r_paddle   <= w_paddle_nxt;
      r_position <= POS_W'(w_paddle_nxt >> POS_SHIFT);
    end
  end

  assign bus.POSITION   = r_position;
  assign bus.TARGET     = r_target;
  assign bus.PRED_VALID = r_pred_valid;
  assign bus.BUSY       = (r_state == StFold) || (r_state == StClamp);

endmodule

// File: tb/tb_ai_predictor.sv
// tb_ai_predictor: directed self-checking bench for ai_predictor (SPEED_DIV=4, other defaults).
// Define PONG_AI_JITTER_EN to replace the exact-target tests with the jitter range test.
module tb_ai_predictor;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ai_predictor_if #(.HW(11), .POS_W(8)) bus ();

  ai_predictor #(.SPEED_DIV(4)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Call on a negedge; returns on the negedge after the capturing posedge.
  task automatic send(input int h, input int v);
    bus.BALL_STEP = 1'b1;
    bus.BALL_H    = 11'(h);
    bus.BALL_V    = 11'(v);
    @(negedge clk);
    bus.BALL_STEP = 1'b0;
  endtask

  // k counts negedges after the posedge that captured the direction step.
  task automatic wait_pred(output int k);
    k = 1;
    while (!bus.PRED_VALID && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k, cycles, maxpos, seen;
    int tmin, tmax;
    rst = 1'b1;
    bus.BALL_STEP = 1'b0;
    bus.BALL_H = '0;
    bus.BALL_V = '0;
    repeat (3) @(negedge clk);
    chk("rst_target", bus.TARGET, 221);
    chk("rst_position", bus.POSITION, 110);
    chk("rst_pred", bus.PRED_VALID, 0);
    chk("rst_busy", bus.BUSY, 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef PONG_AI_JITTER_EN
    tmin = 9999;
    tmax = -1;
    for (int i = 0; i < 64; i++) begin
      send(390, 50);
      send(391, 51);
      wait_pred(k);
      chk("jit_lat", k, 3);
      chk("jit_range", (bus.TARGET >= 406 && bus.TARGET <= 421), 1);
      if (int'(bus.TARGET) < tmin) tmin = int'(bus.TARGET);
      if (int'(bus.TARGET) > tmax) tmax = int'(bus.TARGET);
      repeat (1 + (i % 3)) @(negedge clk);
    end
    chk("jit_varies", (tmax != tmin), 1);
`else
    // Straight down, no bounce.
    send(390, 50);
    send(391, 51);
    chk("t1_busy", bus.BUSY, 1);
    wait_pred(k);
    chk("t1_latency", k, 3);
    chk("t1_target", bus.TARGET, 414);
    @(negedge clk);
    chk("t1_pulse_end", bus.PRED_VALID, 0);

    // Slew from home 221 to 414: 193 ticks of 4 clocks, never overshooting.
    cycles = 1;
    maxpos = int'(bus.POSITION);
    while (bus.POSITION != 207 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (int'(bus.POSITION) > maxpos) maxpos = int'(bus.POSITION);
    end
    chk("slew_time", (cycles >= 769 && cycles <= 772), 1);
    repeat (40) begin
      @(negedge clk);
      if (int'(bus.POSITION) > maxpos) maxpos = int'(bus.POSITION);
    end
    chk("slew_hold", bus.POSITION, 207);
    chk("slew_max", maxpos, 207);

    // Ball turns back at the net: home target, no prediction pulse.
    send(390, 200);
    send(389, 201);
    chk("t4_target", bus.TARGET, 221);
    chk("t4_pred", bus.PRED_VALID, 0);
    chk("t4_busy", bus.BUSY, 0);

    // Repeated net-column step recaptures v0 (60 -> raw 440 -> 424).
    send(390, 50);
    send(390, 60);
    send(391, 61);
    wait_pred(k);
    chk("recap_latency", k, 3);
    chk("recap_target", bus.TARGET, 424);

    // Bottom bounce: 480 -> 468, 452 saturates to 442.
    send(390, 100);
    send(391, 101);
    wait_pred(k);
    chk("t2_latency", k, 4);
    chk("t2_target", bus.TARGET, 442);

    // Equal rows mean up: -280 -> 280 -> 264.
    send(390, 100);
    send(391, 100);
    wait_pred(k);
    chk("eq_latency", k, 4);
    chk("eq_target", bus.TARGET, 264);

    // Top bounce: -80 -> 80 -> 64.
    send(390, 300);
    send(391, 299);
    wait_pred(k);
    chk("t3_latency", k, 4);
    chk("t3_target", bus.TARGET, 64);

    // Steps off the net column in IDLE are ignored.
    send(500, 50);
    send(391, 51);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.PRED_VALID) seen++;
    end
    chk("ign_pred", seen, 0);
    chk("ign_target", bus.TARGET, 64);
    chk("ign_busy", bus.BUSY, 0);
`endif

    // Reset in the middle of a fold abandons the prediction.
    send(390, 100);
    send(391, 101);
    chk("rf_busy_before", bus.BUSY, 1);
    rst = 1'b1;
    #1;
    chk("rf_busy", bus.BUSY, 0);
    chk("rf_target", bus.TARGET, 221);
    chk("rf_position", bus.POSITION, 110);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.PRED_VALID) seen++;
    end
    chk("rf_no_pred", seen, 0);
    chk("rf_target_after", bus.TARGET, 221);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
